// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter that funnels NREQ writeback requesters into a single
// registered register-file write port. The output stage holds one entry.
// Writes to address 0 are accepted and then silently dropped.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   clr_n      - asynchronous active-low reset
//   req_valid  - per-requester write request (NREQ bits)
//   req_addr   - per-requester address; requester i at [i*AW +: AW]
//   req_data   - per-requester data; requester i at [i*DW +: DW]
//   req_ready  - per-requester accept strobe (one-hot or zero)
//   rf_stall   - register-file write port busy this cycle
//   rf_we      - registered write enable
//   rf_waddr   - registered write address
//   rf_wdata   - registered write data
//   wr_count   - wrapping count of committed writes (nonzero addresses only)
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rf_stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [15:0]          wr_count
);

    localparam int PW = $clog2(NREQ);

    logic          st_valid;
    logic          st_drop;
    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] next_ptr;
    logic          grant_any;
    logic          stage_free;
    logic          accept;
    logic          commit;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    int            cand;

    // Scan requesters starting at the pointer, wrapping around; the first
    // valid one wins. Only req_valid and the pointer feed this search.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int j = 0; j < NREQ; j++) begin
            cand = (int'(ptr) + j) % NREQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    // The stage can take a new entry when empty or when its current entry
    // leaves this cycle. A dropped entry still occupies the stage, so a
    // stall also blocks grants behind it. Reset forces ready low.
    always_comb begin
        stage_free = !st_valid || !rf_stall;
        accept     = grant_any && stage_free && clr_n;
        commit     = st_valid && !st_drop && !rf_stall;
        req_ready  = accept ? (NREQ'(1) << grant_idx) : '0;
        sel_addr   = req_addr[int'(grant_idx)*AW +: AW];
        sel_data   = req_data[int'(grant_idx)*DW +: DW];
        next_ptr   = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
    end

    // Output stage, pointer and commit counter. An accept overwrites the
    // stage even while the previous entry commits, giving one write per
    // cycle; a free stage with no accept simply empties.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_valid <= 1'b0;
            st_drop  <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            ptr      <= '0;
            wr_count <= 16'd0;
        end else begin
            if (commit) begin
                wr_count <= wr_count + 16'd1;
            end
            if (accept) begin
                st_valid <= 1'b1;
                st_drop  <= (sel_addr == '0);
                rf_we    <= (sel_addr != '0);
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                ptr      <= next_ptr;
            end else if (stage_free) begin
                st_valid <= 1'b0;
                st_drop  <= 1'b0;
                rf_we    <= 1'b0;
            end
        end
    end

endmodule
